mux_rr_sequencer: RTL

- Round-robin select generator directly upstream of the 4:1 two-bit channel multiplexer.
- Arbitrates four channel requests and drives the mux select (SEL) plus a one-hot grant.
- Holds each grant for up to DWELL accepted beats.
- Presents a valid/ready handshake so the downstream consumer of the muxed 2-bit data knows when it is meaningful.

---
 rtl/mux_rr_sequencer_pkg.sv | 28 ++
 rtl/mux_rr_sequencer_rr_pick4.sv | 33 +++
 rtl/mux_rr_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/mux_rr_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | mux_rr_sequencer_pkg : shared constants for the round-robin sequencer |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_rr_sequencer_pkg;

  localparam int NUM_CH = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_sequencer_rr_pick4.sv
// +----------------------------------------------------------------------+
// | rr_pick4 : combinational round-robin pick, searching upward from     |
// |            last+1 modulo four                                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick4
  import mux_rr_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  output logic [1:0]        winner,
  output logic              any
);

  logic [1:0] idx;

  assign any = |req;

  // Walk from the farthest candidate back to last+1 so the nearest set bit wins.
  always_comb begin
    winner = last;
    idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (req[idx]) winner = idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_sequencer.sv
// +----------------------------------------------------------------------+
// | mux_rr_sequencer : round-robin select/grant generator for a 4:1 mux  |
// |                    with per-grant dwell limit and valid/ready beats  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_rr_sequencer
  import mux_rr_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] REQ,
  input  logic              READY,
  output logic [1:0]        SEL,
  output logic [NUM_CH-1:0] GNT,
  output logic              VALID,
  output logic              RELEASE
);

  localparam int CW = $clog2(DWELL + 1);

  logic [0:0]    state;
  logic [1:0]    last;
  logic [CW-1:0] count;
  logic [1:0]    winner;
  logic          any;
  logic          req_sel;
  logic          accept;
  logic          at_limit;
  logic          rel;

  rr_pick4 u_pick (
    .req    (REQ),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  assign req_sel  = REQ[SEL];
  assign VALID    = (state == ST_GRANT) && req_sel;
  assign accept   = VALID && READY;
  assign at_limit = (count == CW'(DWELL - 1));
  // A dropped request ends the grant even if no beat was taken this cycle.
  assign rel      = (state == ST_GRANT) && (!req_sel || (accept && at_limit));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      SEL     <= CH_A;
      GNT     <= '0;
      RELEASE <= 1'b0;
      count   <= '0;
      last    <= CH_D;
    end else begin
      RELEASE <= rel;
      if (state == ST_IDLE) begin
        if (any) begin
          state <= ST_GRANT;
          SEL   <= winner;
          GNT   <= onehot4(winner);
          count <= '0;
        end
      end else begin
        if (rel) begin
          state <= ST_IDLE;
          GNT   <= '0;
          last  <= SEL;
          count <= '0;
        end else if (accept) begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
